gray_to_yuv422: RTL and testbench
=================================

# gray_to_yuv422

Converts a packed grayscale AXI4-Stream video stream into the packed YUV 4:2:2 bus format used by the stereovision pipeline, inserting neutral chroma. It sits at the output side of the disparity/gray processing path, feeding display and VDMA blocks that expect YUV 4:2:2. It also provides:
- a frame-sync gate that discards input until the first start-of-frame;
- line-length checking with regenerated `tlast`;
- a full-throughput skid buffer, so backpressure is handled without data loss.

## Interface
- `DATA_WIDTH`, 8: bits per pixel component.
- `PPC`, 4: pixels per clock (beat).
- `LINE_BEATS`, 480: beats per video line (line width / `PPC`); must be ≥ 2.
- `aclk`, in, 1: single clock for the whole block.
- `aresetn`, in, 1: reset, asynchronous, active-low.
- `s_axis_gray_tvalid`, in, 1: input beat valid.
- `s_axis_gray_tready`, out, 1: block can accept an input beat.
- `s_axis_gray_tdata`, in, `DATA_WIDTH*PPC`: pixel k occupies `[k*DW +: DW]`, where DW = `DATA_WIDTH`.
- `s_axis_gray_tuser`, in, 1: start of frame.
- `s_axis_gray_tlast`, in, 1: end of line.
- `m_axis_yuv_tvalid`, out, 1: output beat valid.
- `m_axis_yuv_tready`, in, 1: downstream can accept.
- `m_axis_yuv_tdata`, out, `DATA_WIDTH*PPC*3`: YUV 4:2:2 bus.
  - Pixel k: chroma at `[2k*DW +: DW]`, Y at `[(2k+1)*DW +: DW]`.
  - Bits `[2*PPC*DW +: PPC*DW]` are always 0.
- `m_axis_yuv_tuser`, out, 1: start of frame.
- `m_axis_yuv_tlast`, out, 1: end of line (regenerated).
- `err_early_eol`, out, 1: sticky flag; input `tlast` arrived before beat `LINE_BEATS-1`.
- `err_late_eol`, out, 1: sticky flag; beat `LINE_BEATS-1` arrived without input `tlast`.

## Operation
**Conversion**
- Y = input pixel k.
- Chroma = `1 << (DATA_WIDTH-1)` (0x80 for DW=8) for both U (even k) and V (odd k).

**Input acceptance**
- An input beat is accepted when `s_tvalid & s_tready`.
- An output beat is transferred when `m_tvalid & m_tready`.

**State machine (2 states)**
- `WAIT_SOF`:
  - `s_tready` = 1.
  - Accepted beats with `tuser=0` are discarded.
  - An accepted beat with `tuser=1` is forwarded as beat 0; the line counter is set to 1 (or 0 if that beat is also the line end); go to `STREAM`.
- `STREAM`: every accepted beat is forwarded and the line counter `cnt` (0..`LINE_BEATS-1`) runs.
  - Output `tlast` = `in_tlast | (cnt == LINE_BEATS-1)`; `cnt` wraps to 0 on either condition.
  - `in_tlast & cnt != LINE_BEATS-1` → set `err_early_eol`.
  - `cnt == LINE_BEATS-1 & !in_tlast` → set `err_late_eol`.
  - An accepted beat with `tuser=1` is treated as beat 0: `cnt` is reset and the beat is forwarded with `tuser=1`; there is no error flag for a mid-line SOF.
- Error flags clear only on reset.

**Reset**
- All outputs are 0 during reset: `m_tvalid`, `m_tdata`, `m_tuser`, `m_tlast`, both error flags.
- `s_axis_gray_tready` = 0 while `aresetn` is low and rises on the first clock edge after release.
- State = `WAIT_SOF`, `cnt` = 0, skid buffer empty.
- Reset asserted mid-frame drops all buffered beats immediately; after release, the block waits for a new SOF.

## Timing
**Latency and throughput**
- Latency is 1 cycle, input acceptance to `m_tvalid`.
- Sustained throughput is 1 beat/clk with `m_tready=1`.

**Output register and skid buffer**
- The output register plus one skid register gives 2 entries total.
- `s_axis_gray_tready` is registered and equals "skid empty"; there is no combinational path from `m_tready` to `s_tready`.
- When `m_tready` drops while the output is full and an input beat is accepted, the beat goes to the skid register and `s_tready` falls the next cycle.
- When `m_tready` rises: skid → output, and `s_tready` rises the next cycle.
- Simultaneous input accept and output transfer with the skid empty: the output register reloads directly, with no bubble.

**AXI-Stream rules**
- `m_tvalid`, once high, holds with stable `m_tdata`, `m_tuser` and `m_tlast` until transferred.

**Error flags**
- `err_*` flags assert 1 cycle after the offending beat is accepted.

## Structure
**Package `stereovision_pkg`**
- `typedef enum logic {WAIT_SOF, STREAM} g2y_state_t`.
- Function `chroma_neutral(width)`.

**Sub-module `axis_skid_buffer`**
- Parameterised by payload width: tdata + tuser + tlast.
- Reusable elsewhere in the pipeline.
- Conversion, the state machine and the counter stay in the top module, ahead of the skid buffer.

## Test plan
Conditions: DW=8, PPC=4, `LINE_BEATS=4` unless noted.

1. **Reset values:** hold `aresetn=0` → all outputs 0 and `s_tready=0`; release → `s_tready=1` after one edge.
2. **Conversion:** SOF beat `0x11223344` → 1 cycle later `m_tdata` = 0x0000_0000_1180_2280_3380_4480, `tuser=1`.
3. **SOF gating:** 3 beats with `tuser=0`, then `tuser=1` → only the 4th and later beats appear; the first output has `tuser=1`.
4. **Backpressure:** continuous input with `m_tready` low for 5 cycles → `s_tready` low within 2 cycles; output sequence is identical to input with no loss or duplication; full rate resumes with no bubble.
5. **Line checks:**
   - `tlast` on beat 2 → output `tlast` on beat 2, `err_early_eol=1`, next beat counted as 0.
   - No `tlast` on beat 3 → output `tlast=1` on beat 3, `err_late_eol=1`.
6. **Reset mid-frame:** `aresetn` low with 2 beats buffered → `m_tvalid` drops immediately; after release, non-SOF beats are discarded.

Source files
------------

// File: rtl/stereovision_pkg.sv
// Shared types and helpers for the stereovision output path.
package stereovision_pkg;

  typedef enum logic {WAIT_SOF = 1'b0, STREAM = 1'b1} g2y_state_t;

  // Mid-scale code: zero chroma for unsigned U/V.
  function automatic int unsigned chroma_neutral(input int unsigned width);
    return 32'd1 << (width - 32'd1);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice: output register plus one skid register.
// in_ready_o is registered and equals "skid empty", cutting the ready path.
module axis_skid_buffer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [Width-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] skid_data_q, skid_data_d;
  logic             accept;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    accept       = in_valid_i & in_ready_q;
    if (!out_valid_q || out_ready_i) begin
      // Output slot frees up this cycle; the skid entry is older than any new beat.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/gray_to_yuv422.sv
// Packed grayscale AXI-Stream to YUV 4:2:2 with neutral chroma, SOF gating,
// line-length checking with regenerated tlast, and a skid-buffered output.
module gray_to_yuv422
  import stereovision_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PPC        = 4,
  parameter int unsigned LINE_BEATS = 480
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        s_axis_gray_tvalid,
  output logic                        s_axis_gray_tready,
  input  logic [DATA_WIDTH*PPC-1:0]   s_axis_gray_tdata,
  input  logic                        s_axis_gray_tuser,
  input  logic                        s_axis_gray_tlast,
  output logic                        m_axis_yuv_tvalid,
  input  logic                        m_axis_yuv_tready,
  output logic [DATA_WIDTH*PPC*3-1:0] m_axis_yuv_tdata,
  output logic                        m_axis_yuv_tuser,
  output logic                        m_axis_yuv_tlast,
  output logic                        err_early_eol,
  output logic                        err_late_eol
);

  localparam int unsigned InW  = DATA_WIDTH * PPC;
  localparam int unsigned OutW = InW * 3;
  localparam int unsigned PayW = OutW + 2;
  localparam int unsigned CntW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [DATA_WIDTH-1:0] Chroma  = DATA_WIDTH'(chroma_neutral(DATA_WIDTH));
  localparam logic [CntW-1:0]       LastCnt = CntW'(LINE_BEATS - 1);

  g2y_state_t      state_q;
  logic [CntW-1:0] cnt_q;
  logic            err_early_q, err_late_q;

  logic [OutW-1:0] yuv;
  logic [CntW-1:0] cnt_eff;
  logic            fwd, accept, at_end, out_last;
  logic            skid_ready;
  logic [PayW-1:0] pay_in, pay_out;

  always_comb begin
    yuv = '0;
    for (int unsigned k = 0; k < PPC; k++) begin
      yuv[2*k*DATA_WIDTH +: DATA_WIDTH]     = Chroma;
      yuv[(2*k+1)*DATA_WIDTH +: DATA_WIDTH] = s_axis_gray_tdata[k*DATA_WIDTH +: DATA_WIDTH];
    end
    fwd      = s_axis_gray_tvalid & ((state_q == STREAM) | s_axis_gray_tuser);
    accept   = fwd & skid_ready;
    // An SOF beat always restarts the line, whether or not we are synced yet.
    cnt_eff  = s_axis_gray_tuser ? '0 : cnt_q;
    at_end   = (cnt_eff == LastCnt);
    out_last = s_axis_gray_tlast | at_end;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= WAIT_SOF;
      cnt_q       <= '0;
      err_early_q <= 1'b0;
      err_late_q  <= 1'b0;
    end else if (accept) begin
      state_q <= STREAM;
      cnt_q   <= out_last ? '0 : cnt_eff + CntW'(1);
      if (s_axis_gray_tlast && !at_end) err_early_q <= 1'b1;
      if (at_end && !s_axis_gray_tlast) err_late_q <= 1'b1;
    end
  end

  assign pay_in = {out_last, s_axis_gray_tuser, yuv};

  axis_skid_buffer #(
    .Width(PayW)
  ) u_skid (
    .clk_i      (aclk),
    .rst_ni     (aresetn),
    .in_valid_i (fwd),
    .in_ready_o (skid_ready),
    .in_data_i  (pay_in),
    .out_valid_o(m_axis_yuv_tvalid),
    .out_ready_i(m_axis_yuv_tready),
    .out_data_o (pay_out)
  );

  assign s_axis_gray_tready = skid_ready;
  assign m_axis_yuv_tdata   = pay_out[OutW-1:0];
  assign m_axis_yuv_tuser   = pay_out[OutW];
  assign m_axis_yuv_tlast   = pay_out[OutW+1];
  assign err_early_eol      = err_early_q;
  assign err_late_eol       = err_late_q;

endmodule

// File: tb/tb_gray_to_yuv422.sv
// Directed bench for gray_to_yuv422: vector table plus backpressure and reset sequences.
module tb_gray_to_yuv422;

  localparam int DW = 8;
  localparam int PPC = 4;
  localparam int LB = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [31:0]   s_tdata = '0;
  logic          s_tuser = 1'b0;
  logic          s_tlast = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [95:0]   m_tdata;
  logic          m_tuser;
  logic          m_tlast;
  logic          err_early;
  logic          err_late;

  int n_checks = 0;
  int n_fail = 0;

  always #5 aclk = ~aclk;

  gray_to_yuv422 #(
    .DATA_WIDTH(DW),
    .PPC       (PPC),
    .LINE_BEATS(LB)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .s_axis_gray_tvalid(s_tvalid),
    .s_axis_gray_tready(s_tready),
    .s_axis_gray_tdata (s_tdata),
    .s_axis_gray_tuser (s_tuser),
    .s_axis_gray_tlast (s_tlast),
    .m_axis_yuv_tvalid (m_tvalid),
    .m_axis_yuv_tready (m_tready),
    .m_axis_yuv_tdata  (m_tdata),
    .m_axis_yuv_tuser  (m_tuser),
    .m_axis_yuv_tlast  (m_tlast),
    .err_early_eol     (err_early),
    .err_late_eol      (err_late)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] conv(input logic [31:0] g);
    logic [95:0] r;
    r = '0;
    for (int k = 0; k < PPC; k++) begin
      r[16*k +: 8]     = 8'h80;
      r[16*k + 8 +: 8] = g[8*k +: 8];
    end
    return r;
  endfunction

  typedef struct {
    logic [31:0] gray;
    logic        user;
    logic        last;
    logic        e_valid;
    logic        e_user;
    logic        e_last;
    logic        e_early;
    logic        e_late;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] g, input logic u, input logic l,
                              input logic ev, input logic eu, input logic el,
                              input logic ee, input logic elt);
    vec_t v;
    v.gray = g; v.user = u; v.last = l;
    v.e_valid = ev; v.e_user = eu; v.e_last = el; v.e_early = ee; v.e_late = elt;
    return v;
  endfunction

  vec_t        vecs[17];
  logic [31:0] q[$];
  logic [31:0] seq;
  logic [95:0] out_data;
  logic [95:0] hold;
  logic [95:0] conv_exp;
  logic        do_in, do_out;

  task automatic cycle();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    //      gray          u  l  ev eu el ee lt
    vecs[0]  = mk(32'hAAAAAAAA, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(32'hBBBBBBBB, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(32'hCCCCCCCC, 0, 1, 0, 0, 0, 0, 0);
    vecs[3]  = mk(32'h11223344, 1, 0, 1, 1, 0, 0, 0);
    vecs[4]  = mk(32'h55667788, 0, 0, 1, 0, 0, 0, 0);
    vecs[5]  = mk(32'h99AABBCC, 0, 0, 1, 0, 0, 0, 0);
    vecs[6]  = mk(32'hDDEEFF00, 0, 1, 1, 0, 1, 0, 0);
    vecs[7]  = mk(32'h01020304, 0, 0, 1, 0, 0, 0, 0);
    vecs[8]  = mk(32'h05060708, 0, 0, 1, 0, 0, 0, 0);
    vecs[9]  = mk(32'h090A0B0C, 0, 1, 1, 0, 1, 1, 0);
    vecs[10] = mk(32'h0D0E0F10, 0, 0, 1, 0, 0, 1, 0);
    vecs[11] = mk(32'h14151617, 0, 0, 1, 0, 0, 1, 0);
    vecs[12] = mk(32'h18191A1B, 0, 0, 1, 0, 0, 1, 0);
    vecs[13] = mk(32'h1C1D1E1F, 0, 0, 1, 0, 1, 1, 1);
    vecs[14] = mk(32'h20212223, 0, 0, 1, 0, 0, 1, 1);
    vecs[15] = mk(32'h24252627, 0, 0, 1, 0, 0, 1, 1);
    vecs[16] = mk(32'h28292A2B, 1, 0, 1, 1, 0, 1, 1);
    conv_exp = 96'h0000_0000_1180_2280_3380_4480;

    // Reset values
    #12;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tready", s_tready, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tuser", m_tuser, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_err_early", err_early, 0);
    check("rst_err_late", err_late, 0);
    aresetn = 1'b1;
    #1;
    check("rel_tready_before_edge", s_tready, 0);
    cycle();
    check("rel_tready_after_edge", s_tready, 1);

    // Table: SOF gating, conversion, line checks, mid-line SOF
    for (int i = 0; i < 17; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = vecs[i].gray;
      s_tuser  = vecs[i].user;
      s_tlast  = vecs[i].last;
      check($sformatf("v%0d_tready", i), s_tready, 1);
      cycle();
      check($sformatf("v%0d_tvalid", i), m_tvalid, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        check($sformatf("v%0d_tdata", i), m_tdata, conv(vecs[i].gray));
        check($sformatf("v%0d_tuser", i), m_tuser, vecs[i].e_user);
        check($sformatf("v%0d_tlast", i), m_tlast, vecs[i].e_last);
      end
      if (i == 3) check("conv_literal", m_tdata, conv_exp);
      check($sformatf("v%0d_err_early", i), err_early, vecs[i].e_early);
      check($sformatf("v%0d_err_late", i), err_late, vecs[i].e_late);
    end
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    cycle();
    check("idle_tvalid", m_tvalid, 0);

    // Backpressure: continuous input, m_tready low for cycles 5..9
    seq = 32'h1000_0000;
    hold = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      m_tready = !(cyc >= 5 && cyc < 10);
      s_tvalid = 1'b1;
      s_tdata  = seq;
      if (cyc >= 1) check($sformatf("bp_valid_c%0d", cyc), m_tvalid, 1);
      if (cyc == 5) hold = m_tdata;
      if (cyc > 5 && cyc < 10) check($sformatf("bp_stable_c%0d", cyc), m_tdata, hold);
      if (cyc == 7) check("bp_tready_low", s_tready, 0);
      if (cyc == 12) check("bp_tready_high", s_tready, 1);
      do_in    = s_tvalid & s_tready;
      do_out   = m_tvalid & m_tready;
      out_data = m_tdata;
      cycle();
      if (do_out) begin
        if (q.size() == 0) check("bp_extra_beat", 1, 0);
        else check("bp_data", out_data, conv(q.pop_front()));
      end
      if (do_in) begin
        q.push_back(seq);
        seq = seq + 32'h0101_0101;
      end
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int n = 0; n < 10 && q.size() > 0; n++) begin
      do_out   = m_tvalid & m_tready;
      out_data = m_tdata;
      cycle();
      if (do_out) check("drain_data", out_data, conv(q.pop_front()));
    end
    check("drain_empty", q.size(), 0);
    cycle();
    check("drain_tvalid", m_tvalid, 0);

    // Reset with output and skid both full
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 32'hA1A2A3A4;
    cycle();
    s_tdata  = 32'hB1B2B3B4;
    cycle();
    s_tvalid = 1'b0;
    check("full_tvalid", m_tvalid, 1);
    check("full_tready", s_tready, 0);
    #2;
    aresetn = 1'b0;
    #1;
    check("mrst_tvalid", m_tvalid, 0);
    check("mrst_tready", s_tready, 0);
    check("mrst_err_early", err_early, 0);
    check("mrst_err_late", err_late, 0);
    @(negedge aclk);
    aresetn  = 1'b1;
    m_tready = 1'b1;
    cycle();
    check("mrst_tready_back", s_tready, 1);
    s_tvalid = 1'b1;
    s_tdata  = 32'hC1C2C3C4;
    s_tuser  = 1'b0;
    cycle();
    check("mrst_discard", m_tvalid, 0);
    s_tdata = 32'h0A0B0C0D;
    s_tuser = 1'b1;
    cycle();
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    check("mrst_sof_valid", m_tvalid, 1);
    check("mrst_sof_user", m_tuser, 1);
    check("mrst_sof_data", m_tdata, conv(32'h0A0B0C0D));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
